// File: rtl/stream_mux_rr.sv
// NCH:1 valid/ready stream multiplexer with a single registered output stage.
// Round-robin by default; define STREAM_MUX_FIXED_PRIO_EN for fixed priority (lowest index wins).
module stream_mux_rr #(
    parameter int WIDTH = 2,
    parameter int NCH   = 3,
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    localparam logic [SELW:0]   NCH_W  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_W = SELW'(NCH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_chan;

    logic             w_load;
    logic [SELW-1:0]  w_base;
    logic [SELW-1:0]  w_cand_idx [NCH];
    logic [NCH-1:0]   w_cand_vld;
    logic             w_grant_vld;
    logic [SELW-1:0]  w_grant_idx;
    logic [WIDTH-1:0] w_chan_data [NCH];
    logic [WIDTH-1:0] w_sel_data;

    assign w_load = !r_out_valid || out_ready;

`ifdef STREAM_MUX_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_next;

    assign w_base     = r_ptr;
    assign w_ptr_next = (w_grant_idx == LAST_W) ? '0 : w_grant_idx + SELW'(1);

    // Priority only rotates when a beat is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_load && w_grant_vld) begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    // Scan position gi maps to channel (base + gi) mod NCH; base < NCH so one subtract suffices.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_scan
            logic [SELW:0] w_sum;
            assign w_sum           = {1'b0, w_base} + (SELW+1)'(gi);
            assign w_cand_idx[gi]  = (w_sum >= NCH_W) ? SELW'(w_sum - NCH_W) : SELW'(w_sum);
            assign w_cand_vld[gi]  = in_valid[w_cand_idx[gi]];
            assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_cand_vld[k]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand_idx[k];
            end
        end
    end

    assign w_sel_data = w_chan_data[w_grant_idx];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = w_load && w_grant_vld && (w_grant_idx == SELW'(gi)) && !rst;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_grant_idx;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (WIDTH=2, NCH=3) plus throughput and stall sequences.
module tb_stream_mux_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_data;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(2), .NCH(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    typedef struct {
        logic       rst;
        logic [2:0] vld;
        logic [5:0] data;
        logic       ordy;
        logic [2:0] e_ir;
        logic       e_ov;
        logic [1:0] e_od;
        logic [1:0] e_oc;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] D_ALL = 6'b11_10_01;

    task automatic add(input logic r, input logic [2:0] v, input logic [5:0] d, input logic ord,
                       input logic [2:0] ir, input logic ov, input logic [1:0] od, input logic [1:0] oc);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.ordy = ord;
        t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_oc = oc;
        vecs.push_back(t);
    endtask

    task automatic chk_ready(input string name, input logic [2:0] exp);
        n_total++;
        if (in_ready === exp && $countones(in_ready) <= 1) begin
            n_pass++;
            $display("ok   %s in_ready=%b", name, in_ready);
        end else
            $display("FAIL %s in_ready got=%b exp=%b", name, in_ready, exp);
    endtask

    task automatic chk_out(input string name, input logic ov, input logic [1:0] od, input logic [1:0] oc);
        n_total++;
        if (out_valid === ov && out_data === od && out_chan === oc) begin
            n_pass++;
            $display("ok   %s out v=%b d=%b c=%0d", name, out_valid, out_data, out_chan);
        end else
            $display("FAIL %s out got v=%b d=%b c=%0d exp v=%b d=%b c=%0d",
                     name, out_valid, out_data, out_chan, ov, od, oc);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0;
        @(posedge clk); #1;

`ifdef STREAM_MUX_FIXED_PRIO_EN
        add(1, 3'b111, D_ALL, 1, 3'b000, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) add(0, 3'b111, D_ALL, 1, 3'b001, 1, 2'b01, 0);
        add(0, 3'b110, D_ALL, 1, 3'b010, 1, 2'b10, 1);
        add(0, 3'b111, D_ALL, 0, 3'b000, 1, 2'b10, 1);
        add(0, 3'b111, D_ALL, 1, 3'b001, 1, 2'b01, 0);
        add(0, 3'b000, D_ALL, 1, 3'b000, 0, 2'b01, 0);
`else
        add(1, 3'b111, D_ALL,     1, 3'b000, 0, 2'b00, 0);  // reset with all valid
        add(0, 3'b010, 6'b00_11_00, 1, 3'b010, 1, 2'b11, 1); // single ch1, ptr->2
        add(0, 3'b111, D_ALL,     1, 3'b100, 1, 2'b11, 2);  // ptr=2 grants ch2
        add(1, 3'b111, D_ALL,     1, 3'b000, 0, 2'b00, 0);
        for (int i = 0; i < 2; i++) begin                    // round-robin, no bubbles
            add(0, 3'b111, D_ALL, 1, 3'b001, 1, 2'b01, 0);
            add(0, 3'b111, D_ALL, 1, 3'b010, 1, 2'b10, 1);
            add(0, 3'b111, D_ALL, 1, 3'b100, 1, 2'b11, 2);
        end
        for (int i = 0; i < 3; i++)                          // backpressure
            add(0, 3'b111, D_ALL, 0, 3'b000, 1, 2'b11, 2);
        add(0, 3'b111, D_ALL,     1, 3'b001, 1, 2'b01, 0);  // ptr->1
        add(0, 3'b000, D_ALL,     1, 3'b000, 0, 2'b01, 0);  // drain
        add(0, 3'b000, D_ALL,     0, 3'b000, 0, 2'b01, 0);  // idle, ptr kept
        add(0, 3'b111, D_ALL,     1, 3'b010, 1, 2'b10, 1);  // ptr=1 first
        add(0, 3'b101, D_ALL,     1, 3'b100, 1, 2'b11, 2);
        add(0, 3'b010, D_ALL,     1, 3'b010, 1, 2'b10, 1);  // ptr=0, only ch1
        add(0, 3'b001, D_ALL,     1, 3'b001, 1, 2'b01, 0);  // ptr=2 wraps to ch0
        add(1, 3'b111, D_ALL,     0, 3'b000, 0, 2'b00, 0);  // reset discards held beat
`endif

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].data; out_ready = vecs[i].ordy;
            #1;
            chk_ready($sformatf("vec%0d", i), vecs[i].e_ir);
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_oc);
        end

        // Sustained throughput after reset
        rst = 1'b1; in_valid = 3'b111; in_data = D_ALL; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic [1:0] ec;
`ifdef STREAM_MUX_FIXED_PRIO_EN
            ec = 2'd0;
`else
            ec = 2'(i % 3);
`endif
            @(posedge clk); #1;
            chk_out($sformatf("thru%0d", i), 1'b1, ec + 2'd1, ec);
        end

        // Stall while input data changes: output must stay frozen
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] ec;
`ifdef STREAM_MUX_FIXED_PRIO_EN
            ec = 2'd0;
`else
            ec = 2'd2;
`endif
            in_data = 6'($urandom);
            #1;
            chk_ready($sformatf("stall%0d", i), 3'b000);
            @(posedge clk); #1;
            chk_out($sformatf("stall%0d", i), 1'b1, ec + 2'd1, ec);
        end
        in_data = 6'b01_00_10;
        out_ready = 1'b1;
        #1;
        chk_ready("release", 3'b001);
        @(posedge clk); #1;
        chk_out("release", 1'b1, 2'b10, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
